// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - round-robin arbiter sharing one barrel shifter between execute and memory stages
// Optional build macro: SHIFT_ARB_STATS_EN adds the saturating conflict counter.

// Combinational barrel shifter: SLL, SRL, SRA and pass-through.
module shifter_arbiter_barrel #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_PASS = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b11;

  logic                        is_left;
  logic                        fill_bit;
  logic [WIDTH-1:0]            data_rev;
  logic [WIDTH-1:0]            right_out;
  logic [WIDTH-1:0]            right_rev;
  logic [AMT_W:0][WIDTH-1:0]   stage;

  // Left shifts reuse the right-shift network: reverse the operand going in and the result coming out.
  always_comb begin
    is_left  = (op == OP_SLL);
    fill_bit = (op == OP_SRA) ? data[WIDTH-1] : 1'b0;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_rev
    assign data_rev[g]  = data[WIDTH-1-g];
    assign right_rev[g] = right_out[WIDTH-1-g];
  end

  assign stage[0] = is_left ? data_rev : data;

  // One log stage per amount bit; each stage shifts right by 2^s and fills from the top.
  for (genvar s = 0; s < AMT_W; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign stage[s+1] = amount[s] ? {{SH{fill_bit}}, stage[s][WIDTH-1:SH]} : stage[s];
  end

  assign right_out = stage[AMT_W];

  // Final select: pass-through bypasses the network, SLL undoes the reversal.
  always_comb begin
    case (op)
      OP_PASS: result = data;
      OP_SLL:  result = right_rev;
      default: result = right_out;
    endcase
  end

endmodule

// Two-port arbiter in front of the shared shifter with a one-entry result register.
module shifter_arbiter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [AMT_W-1:0] req0_amount,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ack,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [AMT_W-1:0] req1_amount,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [WIDTH-1:0] out_result,
  output logic [CNT_W-1:0] conflict_count
);

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  logic             can_accept;
  logic             both_valid;
  logic             grant_any;
  logic             grant_id;

  logic [1:0]       mux_op;
  logic [AMT_W-1:0] mux_amount;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] shift_result;

  logic             out_valid_q, out_valid_d;
  logic             out_id_q, out_id_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             last_grant_q, last_grant_d;

  // Round-robin grant: a lone request wins, a tie goes to the requester opposite the last winner.
  always_comb begin
    can_accept = !out_valid_q || out_ready;
    both_valid = req0_valid && req1_valid;
    grant_any  = 1'b0;
    grant_id   = ID_REQ0;
    if (can_accept && !rst) begin
      if (both_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (req0_valid) begin
        grant_any = 1'b1;
        grant_id  = ID_REQ0;
      end else if (req1_valid) begin
        grant_any = 1'b1;
        grant_id  = ID_REQ1;
      end
    end
  end

  assign req0_ack = grant_any && (grant_id == ID_REQ0);
  assign req1_ack = grant_any && (grant_id == ID_REQ1);

  // Operand mux; with no grant it parks on requester 0 and the result is simply not captured.
  always_comb begin
    if (grant_any && (grant_id == ID_REQ1)) begin
      mux_op     = req1_op;
      mux_amount = req1_amount;
      mux_data   = req1_data;
    end else begin
      mux_op     = req0_op;
      mux_amount = req0_amount;
      mux_data   = req0_data;
    end
  end

  shifter_arbiter_barrel #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_shifter (
    .op     (mux_op),
    .amount (mux_amount),
    .data   (mux_data),
    .result (shift_result)
  );

  // Output register and arbitration history: capture on grant, drain on a handshake with no new grant.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_result_d = out_result_q;
    last_grant_d = last_grant_q;
    if (grant_any) begin
      out_valid_d  = 1'b1;
      out_id_d     = grant_id;
      out_result_d = shift_result;
      last_grant_d = grant_id;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State flops; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_id_q     <= 1'b0;
      out_result_q <= '0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_result_q <= out_result_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_id     = out_id_q;
  assign out_result = out_result_q;

`ifdef SHIFT_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] conflict_count_q, conflict_count_d;

  // With both valid at most one is acked, so every such cycle leaves one waiting; hold at all-ones.
  always_comb begin
    conflict_count_d = conflict_count_q;
    if (both_valid && (conflict_count_q != CNT_MAX)) begin
      conflict_count_d = conflict_count_q + CNT_ONE;
    end
  end

  // Counter flop, cleared with the rest of the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_count_q <= '0;
    end else begin
      conflict_count_q <= conflict_count_d;
    end
  end

  assign conflict_count = conflict_count_q;
`else
  assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - self-checking bench for shifter_arbiter against a behavioural model
module tb_shifter_arbiter;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [1:0]       req0_op, req1_op;
  logic [AMT_W-1:0] req0_amount, req1_amount;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ack, req1_ack;
  logic             out_valid, out_ready, out_id;
  logic [WIDTH-1:0] out_result;
  logic [CNT_W-1:0] conflict_count;

  int vectors = 0;
  int miscompares = 0;

  logic             m_valid, m_id, m_last;
  logic [WIDTH-1:0] m_result;
  logic [CNT_W-1:0] m_cnt;

  shifter_arbiter #(.WIDTH(WIDTH), .AMT_W(AMT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_amount(req0_amount),
    .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_amount(req1_amount),
    .req1_data(req1_data), .req1_ack(req1_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_result(out_result), .conflict_count(conflict_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op, input logic [AMT_W-1:0] amt,
                                                 input logic [WIDTH-1:0] d);
    case (op)
      2'b00:   return d << amt;
      2'b10:   return d >> amt;
      2'b11:   return WIDTH'($signed(d) >>> amt);
      default: return d;
    endcase
  endfunction

  // Expected acks from the arbitration rules: {ack1, ack0}
  function automatic logic [1:0] ref_acks();
    logic [1:0] a;
    a = 2'b00;
    if (!rst && (!m_valid || out_ready)) begin
      if (req0_valid && req1_valid) a = m_last ? 2'b01 : 2'b10;
      else if (req0_valid)          a = 2'b01;
      else if (req1_valid)          a = 2'b10;
    end
    return a;
  endfunction

  function automatic logic [CNT_W-1:0] exp_count();
`ifdef SHIFT_ARB_STATS_EN
    return m_cnt;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_id = 1'b0; m_result = '0; m_last = 1'b1; m_cnt = '0;
  endtask

  // Advance one clock and update the model with what the edge should do.
  task automatic tick();
    logic [1:0] a;
    a = ref_acks();
    @(posedge clk);
    if (a != 2'b00) begin
      m_result = a[1] ? ref_shift(req1_op, req1_amount, req1_data)
                      : ref_shift(req0_op, req0_amount, req0_data);
      m_id = a[1]; m_valid = 1'b1; m_last = a[1];
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    if (req0_valid && req1_valid && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    #1;
  endtask

  task automatic drive0(input logic v, input logic [1:0] op, input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] d);
    req0_valid = v; req0_op = op; req0_amount = amt; req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [1:0] op, input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] d);
    req1_valid = v; req1_op = op; req1_amount = amt; req1_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive0(1'b1, 2'b00, 5'd1, 32'h1);
    drive1(1'b1, 2'b10, 5'd1, 32'h4);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (out_id !== 1'b0) begin miscompares++; $display("FAIL reset_id: got %b want 0", out_id); end
    vectors++; if (out_result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h want 0", out_result); end
    vectors++; if ({req1_ack, req0_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_acks: got %b want 00", {req1_ack, req0_ack}); end
    vectors++; if (conflict_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", conflict_count); end
    drive0(1'b0, 2'b00, 5'd0, 32'h0);
    drive1(1'b0, 2'b00, 5'd0, 32'h0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_grant();
    out_ready = 1'b1;
    drive0(1'b1, 2'b00, 5'd4, 32'h0000_00FF);
    #2;
    vectors++; if ({req1_ack, req0_ack} !== 2'b01) begin miscompares++; $display("FAIL single_ack: got %b want 01", {req1_ack, req0_ack}); end
    tick();
    drive0(1'b0, 2'b00, 5'd0, 32'h0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %b want 1", out_valid); end
    vectors++; if (out_id !== 1'b0) begin miscompares++; $display("FAIL single_id: got %b want 0", out_id); end
    vectors++; if (out_result !== 32'h0000_0FF0) begin miscompares++; $display("FAIL single_result: got %h want 00000ff0", out_result); end
  endtask

  task automatic test_sra();
    out_ready = 1'b1;
    drive1(1'b1, 2'b11, 5'd8, 32'h8000_0000);
    #2;
    vectors++; if ({req1_ack, req0_ack} !== 2'b10) begin miscompares++; $display("FAIL sra_ack: got %b want 10", {req1_ack, req0_ack}); end
    tick();
    vectors++; if (out_result !== 32'hFF80_0000 || out_id !== 1'b1) begin miscompares++; $display("FAIL sra_result: got %h id %b want ff800000 id 1", out_result, out_id); end
    drive1(1'b1, 2'b10, 5'd8, 32'h8000_0000);
    #2;
    tick();
    vectors++; if (out_result !== 32'h0080_0000 || out_id !== 1'b1) begin miscompares++; $display("FAIL srl_result: got %h id %b want 00800000 id 1", out_result, out_id); end
    drive1(1'b0, 2'b00, 5'd0, 32'h0);
  endtask

  task automatic test_contention();
    logic [1:0] want;
    out_ready = 1'b1;
    drive0(1'b1, 2'b00, 5'd1, 32'h1);
    drive1(1'b1, 2'b10, 5'd1, 32'h4);
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      #2;
      vectors++; if ({req1_ack, req0_ack} !== want) begin miscompares++; $display("FAIL contention_ack[%0d]: got %b want %b", i, {req1_ack, req0_ack}, want); end
      tick();
      vectors++; if (out_result !== 32'h2 || out_id !== want[1]) begin miscompares++; $display("FAIL contention_out[%0d]: got %h id %b want 2 id %b", i, out_result, out_id, want[1]); end
    end
    drive0(1'b0, 2'b00, 5'd0, 32'h0);
    drive1(1'b0, 2'b00, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [CNT_W-1:0] want_cnt;
    out_ready = 1'b1;
    drive0(1'b1, 2'b00, 5'd3, 32'h1);
    #2;
    tick();
    out_ready = 1'b0;
    drive0(1'b1, 2'b00, 5'd1, 32'h1);
    drive1(1'b1, 2'b10, 5'd1, 32'h4);
`ifdef SHIFT_ARB_STATS_EN
    want_cnt = m_cnt + CNT_W'(3);
`else
    want_cnt = '0;
`endif
    for (int i = 0; i < 3; i++) begin
      #2;
      vectors++; if ({req1_ack, req0_ack} !== 2'b00) begin miscompares++; $display("FAIL bp_ack[%0d]: got %b want 00", i, {req1_ack, req0_ack}); end
      tick();
      vectors++; if (out_valid !== 1'b1 || out_result !== 32'h8 || out_id !== 1'b0) begin miscompares++; $display("FAIL bp_hold[%0d]: got v%b %h id %b want v1 00000008 id 0", i, out_valid, out_result, out_id); end
    end
    vectors++; if (conflict_count !== want_cnt) begin miscompares++; $display("FAIL bp_count: got %0d want %0d", conflict_count, want_cnt); end
    out_ready = 1'b1;
    #2;
    vectors++; if ({req1_ack, req0_ack} !== 2'b10) begin miscompares++; $display("FAIL bp_release_ack: got %b want 10", {req1_ack, req0_ack}); end
    tick();
    vectors++; if (out_valid !== 1'b1 || out_result !== 32'h2 || out_id !== 1'b1) begin miscompares++; $display("FAIL bp_release_out: got v%b %h id %b want v1 00000002 id 1", out_valid, out_result, out_id); end
    drive0(1'b0, 2'b00, 5'd0, 32'h0);
    drive1(1'b0, 2'b00, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    drive0(1'b1, 2'b01, 5'd17, 32'hDEAD_BEEF);
    #2;
    tick();
    vectors++; if (out_result !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL pass_result: got %h want deadbeef", out_result); end
    drive0(1'b1, 2'b00, 5'd0, 32'hDEAD_BEEF);
    #2;
    tick();
    vectors++; if (out_result !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL sll0_result: got %h want deadbeef", out_result); end
    drive0(1'b0, 2'b00, 5'd0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    logic [1:0] exp_a;
    logic [1:0] last_a;
    last_a = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || last_a[0]) drive0(($urandom_range(0, 2) != 0), 2'($urandom), 5'($urandom), $urandom);
      else if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
      if (!req1_valid || last_a[1]) drive1(($urandom_range(0, 2) != 0), 2'($urandom), 5'($urandom), $urandom);
      else if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      #2;
      exp_a = ref_acks();
      vectors++; if ({req1_ack, req0_ack} !== exp_a) begin miscompares++; $display("FAIL rand_ack[%0d]: got %b want %b", i, {req1_ack, req0_ack}, exp_a); end
      last_a = exp_a;
      tick();
      vectors++; if (out_valid !== m_valid) begin miscompares++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_valid); end
      if (m_valid) begin
        vectors++; if (out_id !== m_id || out_result !== m_result) begin miscompares++; $display("FAIL rand_out[%0d]: got %h id %b want %h id %b", i, out_result, out_id, m_result, m_id); end
      end
      vectors++; if (conflict_count !== exp_count()) begin miscompares++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, conflict_count, exp_count()); end
    end
    drive0(1'b0, 2'b00, 5'd0, 32'h0);
    drive1(1'b0, 2'b00, 5'd0, 32'h0);
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive0(1'b1, 2'b00, 5'd1, 32'h5);
    #2;
    tick();
    out_ready = 1'b0;
    drive1(1'b1, 2'b10, 5'd1, 32'h4);
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    vectors++; if (out_result !== 32'h0) begin miscompares++; $display("FAIL arst_result: got %h want 0", out_result); end
    vectors++; if ({req1_ack, req0_ack} !== 2'b00) begin miscompares++; $display("FAIL arst_acks: got %b want 00", {req1_ack, req0_ack}); end
    vectors++; if (conflict_count !== '0) begin miscompares++; $display("FAIL arst_count: got %0d want 0", conflict_count); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    drive0(1'b1, 2'b00, 5'd1, 32'h1);
    drive1(1'b1, 2'b10, 5'd1, 32'h4);
    #2;
    vectors++; if ({req1_ack, req0_ack} !== 2'b01) begin miscompares++; $display("FAIL arst_first_conflict: got %b want 01", {req1_ack, req0_ack}); end
    tick();
    vectors++; if (out_id !== 1'b0 || out_result !== 32'h2) begin miscompares++; $display("FAIL arst_after_out: got %h id %b want 00000002 id 0", out_result, out_id); end
    drive0(1'b0, 2'b00, 5'd0, 32'h0);
    drive1(1'b0, 2'b00, 5'd0, 32'h0);
    tick();
  endtask

  initial begin
    drive0(1'b0, 2'b00, 5'd0, 32'h0);
    drive1(1'b0, 2'b00, 5'd0, 32'h0);
    test_reset();
    test_single_grant();
    test_sra();
    test_contention();
    test_backpressure();
    test_passthrough();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
Shares the single barrel shifter between two requesters: port 0 is the execute-stage shift path and port 1 is the memory-stage load/store byte-lane aligner. A round-robin arbiter grants one request per cycle and drives the shifter instance with that request's operands. The result is captured in a one-entry output register with a valid/ready handshake and tagged with the winner's ID. The block sits between both pipeline stages and the shifter; requesters never drive the shifter directly.

Parameters:
WIDTH, 32, data width; this revision supports only 32.
AMT_W, 5, shift-amount width; must equal log2(WIDTH).
CNT_W, 16, conflict-counter width (used only with SHIFT_ARB_STATS_EN).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req0_valid  input  1  requester 0 has an operation.
req0_op  input  2  shift op: 00 SLL, 10 SRL, 11 SRA, 01 pass-through (result = data).
req0_amount  input  AMT_W  shift amount.
req0_data  input  WIDTH  operand.
req0_ack  output  1  requester 0 accepted this cycle.
req1_valid, req1_op, req1_amount, req1_data, req1_ack  same as requester 0, for requester 1.
out_valid  output  1  out_result holds an unconsumed result.
out_ready  input  1  consumer takes the result this cycle.
out_id  output  1  requester that produced out_result.
out_result  output  WIDTH  registered shifter result.
conflict_count  output  CNT_W  stall statistics; zero when the feature is compiled out.

Behaviour:
- Reset (async, immediate): out_valid=0, out_id=0, out_result=0, last_grant=1 (so requester 0 wins the first conflict), conflict_count=0. req0_ack and req1_ack are forced to 0 while rst=1.
- Accept condition: can_accept = !out_valid || out_ready.
- Grant is combinational in the same cycle:
  - If can_accept=0, both acks are 0.
  - Otherwise, if exactly one reqN_valid is set, that requester is granted.
  - If both are valid, grant the requester opposite to last_grant.
  - If neither is valid, nothing is granted.
- reqN_ack = grant to N. At most one ack is high per cycle.
- Requesters must hold valid and operands stable until they see ack. Dropping valid before ack is legal and simply withdraws the request.
- The shifter is fed through a mux on the grant. With no grant, the mux selects requester 0's inputs, and the result is ignored.
- On a clock edge with a grant:
  - out_result <= shifter result
  - out_id <= winner
  - out_valid <= 1
  - last_grant <= winner
- On a clock edge with no grant: if out_ready=1, out_valid <= 0; otherwise out_valid holds.
- Latency: ack in cycle N, result visible with out_valid=1 in cycle N+1.
- Throughput: one operation per cycle while out_ready=1. Back-to-back transfers work because a handshake and a new capture can happen on the same edge.
- Backpressure: while out_valid=1 and out_ready=0, out_result and out_id hold, and no acks are issued.
- last_grant updates only on a grant. Idle cycles do not change it.
- Starvation bound: under continuous contention, each requester waits at most one accepted transfer.
- Shift semantics:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA replicates data[WIDTH-1].
  - amount=0 returns data unchanged for every op.
- Reset mid-operation discards any held result. Acks issued in the reset cycle are void.

Optional Feature:
Macro SHIFT_ARB_STATS_EN.
- When defined: conflict_count increments on every cycle in which both reqN_valid=1 and one requester was not acked. This covers both a round-robin loss and a backpressure stall with both valid.
  - The counter saturates at all-ones.
  - It is cleared by rst.
  - A backpressure cycle with both requests valid counts once.
- When not defined: no counter is built, and conflict_count is a constant 0.

Test Plan:
1. Reset, then one grant. Assert rst, release it, then drive req0 SLL, amount=4, data=0x0000_00FF, with out_ready=1. Expect req0_ack=1 in that cycle; next cycle out_valid=1, out_id=0, out_result=0x0000_0FF0.
2. SRA sign fill. Drive req1 SRA, amount=8, data=0x8000_0000. Expect out_result=0xFF80_0000, out_id=1. Then req1 SRL with the same operands: expect 0x0080_0000.
3. Contention. Hold both valid for 4 cycles (req0 SLL 1 of 0x1, req1 SRL 1 of 0x4). Expect acks in the order 0,1,0,1 and results 0x2,0x2,0x2,0x2 with out_id 0,1,0,1.
4. Backpressure. Hold out_ready=0 after one capture and keep both requests valid for 3 cycles. Expect no acks, and out_result/out_id stable. With SHIFT_ARB_STATS_EN, conflict_count rises by 3; without it, conflict_count stays 0. On release, expect a new capture on the same edge as the handshake.
5. Pass-through and amount 0. Drive op=01, amount=17, data=0xDEAD_BEEF, then SLL with amount=0 on the same data. Expect 0xDEAD_BEEF for both.
6. Asynchronous reset. With out_valid=1 and a pending request, assert rst between clock edges. Expect out_valid, out_result and acks to drop to 0 immediately. After release, the first conflict grants requester 0.
